ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT, default 840: ce ticks the host holds PS/2 clock low before the start bit (120 us at 7 MHz).
REQ-002 SHALL have parameter TIMEOUT, default 105000: ce ticks of watchdog allowed between device clock falling edges (15 ms at 7 MHz).
REQ-003 SHALL have port clock, input, 1: system clock; the block has one clock.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port ce, input, 1: clock enable, nominally 7 MHz (pe7M0); all state advances only when ce=1.
REQ-006 SHALL have port ps2Ck, input, 1: raw PS/2 clock pin level.
REQ-007 SHALL have port ps2D, input, 1: raw PS/2 data pin level.
REQ-008 SHALL have port ckOe, output, 1: 1 = pull PS/2 clock low (open-collector).
REQ-009 SHALL have port dOe, output, 1: 1 = pull PS/2 data low (open-collector).
REQ-010 SHALL have port strb, input, 1: send request, sampled on a ce cycle.
REQ-011 SHALL have port code, input, 8: byte to send to the device (e.g. 0xED set-LEDs).
REQ-012 SHALL have port busy, output, 1: transfer in progress.
REQ-013 SHALL have port done, output, 1: one-ce-cycle pulse at end of transfer.
REQ-014 SHALL have port err, output, 1: qualifies done; 1 = timeout or missing ACK.

Function
REQ-015 SHALL synchronize ps2Ck and ps2D through two flops and detect a clock falling edge as previous=1, current=0 on ce cycles.
REQ-016 SHALL use FSM states IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK, FINISH.
REQ-017 IDLE: on strb=1, latch code, compute odd parity (bit = ~^code), clear the tick counter, set busy=1 and go to INHIBIT.
REQ-018 INHIBIT: ckOe=1 and dOe=0 for INHIBIT ticks, then dOe=1 (start bit) and go to START; ckOe SHALL fall to 0 one ce cycle after dOe rises.
REQ-019 START: on the 1st falling edge, drive bit0 (dOe = ~bit), then go to DATA.
REQ-020 DATA: on falling edges 2..8, drive bits 1..7 LSB-first; after bit7 go to PARITY.
REQ-021 PARITY: on the 9th falling edge, drive the parity bit and go to STOP.
REQ-022 STOP: on the 10th falling edge, set dOe=0 (release) and go to ACK.
REQ-023 ACK: on the 11th falling edge, sample synchronized ps2D; ACK valid when ps2D=0; then go to FINISH.
REQ-024 FINISH: wait for synchronized ps2Ck=1 and ps2D=1, then pulse done for one ce cycle, set err per ACK, clear busy and go to IDLE.
REQ-025 The watchdog SHALL restart on every falling edge and on entry to START; if it reaches TIMEOUT in START..FINISH, it SHALL release both lines, pulse done with err=1 and return to IDLE.
REQ-026 err SHALL hold its value until the next strb accept.
REQ-027 strb while busy=1 SHALL be ignored, with no queueing.
REQ-028 strb and done on the same ce cycle: done completes first and strb is ignored.
REQ-029 ckOe and dOe SHALL never both be 0 while in START..PARITY, unless the data bit is 1.

Reset
REQ-030 reset=0 SHALL asynchronously force IDLE, ckOe=0, dOe=0, busy=0, done=0, err=0, and clear the counter and synchronizers to 1, including mid-transfer.
REQ-031 No done pulse SHALL be emitted for a transfer aborted by reset.

Configuration
REQ-032 With PS2_TX_ACK_CHECK_EN defined, err=1 when the ACK sample is 1.
REQ-033 Without PS2_TX_ACK_CHECK_EN, the ACK sample is ignored and err reflects the watchdog only; the ACK state and 11th edge are still consumed.

Structure
REQ-034 Package ps2_pkg SHALL hold the FSM state enum and command constants: CMD_LEDS=0xED, CMD_ECHO=0xEE, CMD_RESET=0xFF, CMD_ENABLE=0xF4.
REQ-035 Sub-module ps2_sync SHALL provide the two-flop synchronizer and falling-edge detector, reusable by the receiver.
REQ-036 INHIBIT and watchdog SHALL share one 17-bit tick counter.

Verification
REQ-037 Device model ACKs, strb code=0xF4: ckOe high for 840 ticks; dOe = ~bits for 0,0,1,0,1,1,1,1 then parity 0; stop released; done=1, err=0.
REQ-038 code=0xED: data bits 1,0,1,1,0,1,1,1 and parity 1; model decodes 0xED with good parity.
REQ-039 No device clock after the start bit: done=1, err=1 exactly TIMEOUT ticks after entry to START; ckOe=0, dOe=0.
REQ-040 Model leaves data high on the 11th edge: with PS2_TX_ACK_CHECK_EN, err=1; without it, err=0.
REQ-041 Second strb during DATA: ignored, single packet observed; reset=0 asserted after the 4th edge releases both lines immediately with no done pulse.
REQ-042 Back-to-back 0xED then 0x02 after done: two correct packets observed with busy low for at least one ce cycle between them.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM state encoding,
// the shared tick-counter width and common device command bytes.
package ps2_pkg;

    // Width of the shared inhibit / watchdog tick counter
    localparam int CNT_W = 17;

    // Common host-to-device command bytes
    localparam logic [7:0] CMD_LEDS   = 8'hED;
    localparam logic [7:0] CMD_ECHO   = 8'hEE;
    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INHIBIT = 3'd1,
        S_START   = 3'd2,
        S_DATA    = 3'd3,
        S_PARITY  = 3'd4,
        S_STOP    = 3'd5,
        S_ACK     = 3'd6,
        S_FINISH  = 3'd7
    } ps2_tx_state_e;

    // PS/2 frames carry odd parity over the eight data bits
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins plus a clock
// falling-edge detector. Everything advances on clock-enable cycles only,
// and reset parks the pipeline at the idle (high) line level so leaving
// reset never looks like a falling edge.
module ps2_sync (
    input  logic clock,
    input  logic reset,
    input  logic ce,
    input  logic ps2Ck,
    input  logic ps2D,
    output logic ck_o,
    output logic d_o,
    output logic fall_o
);

    logic [1:0] ck_q;
    logic [1:0] d_q;
    logic       ck_prev_q;

    // Shift the raw pins through two flops and remember the previous clock level
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ck_q      <= 2'b11;
            d_q       <= 2'b11;
            ck_prev_q <= 1'b1;
        end else if (ce) begin
            ck_q      <= {ck_q[0], ps2Ck};
            d_q       <= {d_q[0], ps2D};
            ck_prev_q <= ck_q[1];
        end
    end

    assign ck_o   = ck_q[1];
    assign d_o    = d_q[1];
    // One ce cycle wide: previous synchronized level 1, current level 0
    assign fall_o = ce & ck_prev_q & ~ck_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Holds the device clock low for INHIBIT
// ticks, raises the start bit, then shifts out 8 data bits LSB-first, odd
// parity and the stop bit on device clock falling edges, consumes the ACK
// edge and waits for the bus to idle. A watchdog shared with the inhibit
// counter aborts the transfer if the device stops clocking.
// Optional build macro: PS2_TX_ACK_CHECK_EN -- when defined, a missing ACK
// (data high on the 11th edge) is reported through err.
// ckOe/dOe are open-collector enables: 1 pulls the line low.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT = 840,
    parameter int TIMEOUT = 105000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       ps2Ck,
    input  logic       ps2D,
    output logic       ckOe,
    output logic       dOe,
    input  logic       strb,
    input  logic [7:0] code,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

    ps2_tx_state_e    state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       data_q;
    logic             par_q;
    logic [2:0]       bit_idx_q;
    logic             ckoe_q;
    logic             doe_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
`ifdef PS2_TX_ACK_CHECK_EN
    logic             ack_bad_q;
`endif

    logic ck_s;
    logic d_s;
    logic ck_fall;
    logic wd_active;
    logic wd_expired;

    ps2_sync u_sync (
        .clock  (clock),
        .reset  (reset),
        .ce     (ce),
        .ps2Ck  (ps2Ck),
        .ps2D   (ps2D),
        .ck_o   (ck_s),
        .d_o    (d_s),
        .fall_o (ck_fall)
    );

    // Watchdog runs from START to FINISH; a falling edge in the same cycle wins
    assign wd_active  = (state_q != S_IDLE) && (state_q != S_INHIBIT);
    assign wd_expired = wd_active && !ck_fall && (cnt_q == TO_LAST);

    // Transfer FSM with registered line enables and status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            bit_idx_q <= '0;
            ckoe_q    <= 1'b0;
            doe_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
            ack_bad_q <= 1'b0;
`endif
        end else if (ce) begin
            done_q <= 1'b0;
            if (wd_active) begin
                cnt_q <= ck_fall ? '0 : cnt_q + CNT_W'(1);
            end
            if (wd_expired) begin
                ckoe_q  <= 1'b0;
                doe_q   <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                err_q   <= 1'b1;
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (strb) begin
                            data_q  <= code;
                            par_q   <= odd_parity(code);
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            err_q   <= 1'b0;
                            ckoe_q  <= 1'b1;
                            doe_q   <= 1'b0;
                            state_q <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        if (cnt_q == INH_LAST) begin
                            doe_q   <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= S_START;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    S_START: begin
                        // Clock is released one ce cycle after the start bit goes out
                        ckoe_q <= 1'b0;
                        if (ck_fall) begin
                            doe_q     <= ~data_q[0];
                            data_q    <= {1'b0, data_q[7:1]};
                            bit_idx_q <= 3'd1;
                            state_q   <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (ck_fall) begin
                            doe_q  <= ~data_q[0];
                            data_q <= {1'b0, data_q[7:1]};
                            if (bit_idx_q == 3'd7) begin
                                state_q <= S_PARITY;
                            end else begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (ck_fall) begin
                            doe_q   <= ~par_q;
                            state_q <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        if (ck_fall) begin
                            doe_q   <= 1'b0;
                            state_q <= S_ACK;
                        end
                    end
                    S_ACK: begin
                        if (ck_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
                            ack_bad_q <= d_s;
`endif
                            state_q <= S_FINISH;
                        end
                    end
                    S_FINISH: begin
                        if (ck_s && d_s) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
                            err_q   <= ack_bad_q;
`else
                            err_q   <= 1'b0;
`endif
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign ckOe    = ckoe_q;
    assign dOe     = doe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on
// open-collector lines. Small INHIBIT/TIMEOUT values keep runs short.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 20;
    localparam int TO   = 300;
    localparam int HALF = 10;
`ifdef PS2_TX_ACK_CHECK_EN
    localparam logic ACK_ERR_EXP = 1'b1;
`else
    localparam logic ACK_ERR_EXP = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ce     = 1'b1;
    logic       strb   = 1'b0;
    logic [7:0] code   = 8'h00;
    logic       dev_ck = 1'b1;
    logic       dev_d  = 1'b1;
    logic       ck_oe;
    logic       d_oe;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] state;
    wire        ps2_ck = dev_ck & ~ck_oe;
    wire        ps2_d  = dev_d & ~d_oe;

    int checks    = 0;
    int failures  = 0;
    int done_cnt  = 0;

    ps2_host_tx #(
        .INHIBIT (INH),
        .TIMEOUT (TO)
    ) dut (
        .clock   (clk),
        .reset   (rst_n),
        .ce      (ce),
        .ps2Ck   (ps2_ck),
        .ps2D    (ps2_d),
        .ckOe    (ck_oe),
        .dOe     (d_oe),
        .strb    (strb),
        .code    (code),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .state_o (state)
    );

    // clock / run-time guard
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "bench time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 2000) begin
            tick();
            cycles++;
        end
        check(tag, done, 1'b1);
    endtask

    // Device: waits for the start bit, generates n_edges clocks, samples the
    // data line late in each high phase and optionally ACKs on the 11th edge.
    task automatic dev_xfer(input int n_edges, input bit ack, input int strb_edge,
                            output logic [10:0] bits);
        int w;
        w    = 0;
        bits = '1;
        while (!(ck_oe === 1'b0 && d_oe === 1'b1) && w < 1000) begin
            tick();
            w++;
        end
        check("dev_start_seen", (w < 1000), 1'b1);
        repeat (5) tick();
        check("dev_start_bit_low", ps2_d, 1'b0);
        for (int e = 1; e <= n_edges; e++) begin
            if (e == 11 && ack) dev_d = 1'b0;
            dev_ck = 1'b0;
            if (e == strb_edge) begin
                strb = 1'b1;
                tick();
                strb = 1'b0;
                repeat (HALF - 1) tick();
            end else begin
                repeat (HALF) tick();
            end
            dev_ck = 1'b1;
            repeat (HALF) tick();
            bits[e-1] = ps2_d;
        end
        dev_d = 1'b1;
    endtask

    initial begin
        logic [10:0] bits;
        int          n;
        int          dc0;

        // reset state
        repeat (3) tick();
        check("rst_ckoe", ck_oe, 1'b0);
        check("rst_doe", d_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_state", state, S_IDLE);
        rst_n = 1'b1;
        repeat (3) tick();

        // strb with ce low is not seen
        ce = 1'b0; strb = 1'b1; code = CMD_ENABLE;
        repeat (3) tick();
        check("ce_gate_busy", busy, 1'b0);
        strb = 1'b0; ce = 1'b1;
        tick();

        // 0xF4 with ACK: inhibit length, start bit overlap, frame bits
        code = CMD_ENABLE; strb = 1'b1;
        tick();
        strb = 1'b0;
        check("f4_busy", busy, 1'b1);
        n = 0;
        while (ck_oe === 1'b1 && d_oe === 1'b0 && n < 1000) begin
            n++;
            tick();
        end
        check("f4_inhibit_ticks", n, INH);
        check("f4_start_ckoe_held", ck_oe, 1'b1);
        check("f4_start_doe", d_oe, 1'b1);
        tick();
        check("f4_ck_released", ck_oe, 1'b0);
        check("f4_start_doe_kept", d_oe, 1'b1);
        dev_xfer(11, 1'b1, 0, bits);
        check("f4_byte", bits[7:0], 8'hF4);
        check("f4_parity", bits[8], 1'b0);
        check("f4_stop", bits[9], 1'b1);
        wait_done("f4_done", n);
        check("f4_err", err, 1'b0);
        check("f4_busy_clear", busy, 1'b0);
        tick();
        check("f4_done_one_cycle", done, 1'b0);

        // 0xED with a second strb during DATA (and code changed under it)
        dc0 = done_cnt;
        code = CMD_LEDS; strb = 1'b1;
        tick();
        strb = 1'b0;
        code = CMD_RESET;
        dev_xfer(11, 1'b1, 3, bits);
        check("ed_byte", bits[7:0], 8'hED);
        check("ed_parity", bits[8], 1'b1);
        check("ed_stop", bits[9], 1'b1);
        wait_done("ed_done", n);
        check("ed_err", err, 1'b0);
        repeat (40) tick();
        check("ed_no_second_xfer", busy, 1'b0);
        check("ed_single_done", done_cnt, dc0 + 1);

        // no device clock: watchdog fires TIMEOUT ticks after START entry
        code = CMD_ECHO; strb = 1'b1;
        tick();
        strb = 1'b0;
        n = 0;
        while (d_oe !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        check("to_start_seen", d_oe, 1'b1);
        wait_done("to_done", n);
        check("to_cycles", n, TO);
        check("to_err", err, 1'b1);
        check("to_ckoe", ck_oe, 1'b0);
        check("to_doe", d_oe, 1'b0);
        check("to_busy", busy, 1'b0);
        repeat (5) tick();
        check("to_err_held", err, 1'b1);

        // missing ACK: data left high on the 11th edge
        dc0 = done_cnt;
        code = CMD_ENABLE; strb = 1'b1;
        tick();
        strb = 1'b0;
        check("nack_err_cleared", err, 1'b0);
        dev_xfer(11, 1'b0, 0, bits);
        repeat (10) tick();
        check("nack_byte", bits[7:0], 8'hF4);
        check("nack_done_seen", done_cnt, dc0 + 1);
        check("nack_err", err, ACK_ERR_EXP);
        check("nack_busy", busy, 1'b0);

        // reset after the 4th edge: lines released at once, no done
        code = CMD_LEDS; strb = 1'b1;
        tick();
        strb = 1'b0;
        dev_xfer(4, 1'b0, 0, bits);
        check("rstmid_state", state, S_DATA);
        check("rstmid_busy_before", busy, 1'b1);
        dc0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("rstmid_ckoe", ck_oe, 1'b0);
        check("rstmid_doe", d_oe, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (30) tick();
        check("rstmid_no_done", done_cnt, dc0);
        check("rstmid_idle", state, S_IDLE);

        // back-to-back 0xED then 0x02, strb already high on the done cycle
        code = CMD_LEDS; strb = 1'b1;
        tick();
        strb = 1'b0;
        dev_xfer(11, 1'b1, 0, bits);
        check("b2b1_byte", bits[7:0], 8'hED);
        check("b2b1_parity", bits[8], 1'b1);
        code = 8'h02; strb = 1'b1;
        wait_done("b2b1_done", n);
        check("b2b1_err", err, 1'b0);
        check("b2b1_busy_gap", busy, 1'b0);
        tick();
        strb = 1'b0;
        check("b2b2_accepted", busy, 1'b1);
        check("b2b2_done_low", done, 1'b0);
        dev_xfer(11, 1'b1, 0, bits);
        check("b2b2_byte", bits[7:0], 8'h02);
        check("b2b2_parity", bits[8], 1'b0);
        check("b2b2_stop", bits[9], 1'b1);
        wait_done("b2b2_done", n);
        check("b2b2_err", err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
